// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end. Owns the program counter, reads
// the combinational instruction memory, and presents one instruction at a
// time to decode through a valid/ready register. Redirects (JR > J/JAL >
// branch) arrive with the handshake of the presented instruction; a halt
// word stops fetching until reset.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_adr,
    input  logic [31:0] imem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4,
    input  logic        br_taken,
    input  logic [15:0] br_imm,
    input  logic        jmp,
    input  logic [25:0] jmp_addr,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_out_valid;
    logic [31:0] r_out_inst;
    logic [31:0] r_out_pc;
    logic [31:0] r_fetch_count;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_valid_nxt;
    logic [31:0] w_inst_nxt;
    logic [31:0] w_out_pc_nxt;

    logic        w_hs;
    logic        w_redir;
    logic        w_load;
    logic        w_is_halt;
    logic [31:0] w_out_pc4;
    logic [31:0] w_br_off;
    logic [31:0] w_br_target;
    logic [31:0] w_jmp_target;
    logic [31:0] w_target;

    assign w_hs      = r_out_valid & out_ready;
    assign w_redir   = w_hs & (br_taken | jmp | jr);
    assign w_load    = (r_state == ST_RUN) & (~r_out_valid | out_ready) & ~w_redir;
    assign w_is_halt = (imem_data == HALT_WORD);

    assign w_out_pc4    = r_out_pc + 32'd4;
    assign w_br_off     = {{14{br_imm[15]}}, br_imm, 2'b00};
    assign w_br_target  = w_out_pc4 + w_br_off;
    assign w_jmp_target = {w_out_pc4[31:28], jmp_addr, 2'b00};

    // Redirect target selection: JR beats J/JAL beats a taken branch.
    always_comb begin
        w_target = w_br_target;
        if (jmp) w_target = w_jmp_target;
        if (jr)  w_target = jr_target;
    end

    // Next-state and next-register values for one cycle, in event priority order.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_valid_nxt  = r_out_valid;
        w_inst_nxt   = r_out_inst;
        w_out_pc_nxt = r_out_pc;
        if (w_redir) begin
            // The word currently on imem_data belongs to the wrong path.
            w_pc_nxt    = w_target;
            w_valid_nxt = 1'b0;
        end else if (w_load && w_is_halt) begin
            // pc stays on the halt word so imem_adr keeps pointing at it.
            w_state_nxt = ST_HALT;
            w_valid_nxt = 1'b0;
        end else if (w_load) begin
            w_inst_nxt   = imem_data;
            w_out_pc_nxt = r_pc;
            w_valid_nxt  = 1'b1;
            w_pc_nxt     = r_pc + 32'd4;
        end else if (w_hs) begin
            w_valid_nxt = 1'b0;
        end
    end

    // State, pc, output register and handshake counter; reset wins over all.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_out_valid   <= 1'b0;
            r_out_inst    <= 32'd0;
            r_out_pc      <= 32'd0;
            r_fetch_count <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_inst  <= w_inst_nxt;
            r_out_pc    <= w_out_pc_nxt;
            if (w_hs) r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign imem_adr    = r_pc;
    assign out_valid   = r_out_valid;
    assign out_inst    = r_out_inst;
    assign out_pc      = r_out_pc;
    assign out_pc4     = w_out_pc4;
    assign halted      = (r_state == ST_HALT);
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus for fetch_stage. The stimulus process
// pushes the expected (pc, inst) of every instruction it intends to accept;
// a monitor pops and compares on each handshake. Memory word at address a
// is 32'h1234_0000 + a, except address 16 holds the halt word in halt mode.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic [31:0] imem_adr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic        br_taken;
    logic [15:0] br_imm;
    logic        jmp;
    logic [25:0] jmp_addr;
    logic        jr;
    logic [31:0] jr_target;
    logic        halted;
    logic [31:0] fetch_count;
    logic        halt_mode;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t exp_q[$];
    int   total;
    int   bad;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .imem_adr   (imem_adr),
        .imem_data  (imem_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_pc     (out_pc),
        .out_pc4    (out_pc4),
        .br_taken   (br_taken),
        .br_imm     (br_imm),
        .jmp        (jmp),
        .jmp_addr   (jmp_addr),
        .jr         (jr),
        .jr_target  (jr_target),
        .halted     (halted),
        .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1234_0000 + a;
    endfunction

    // Instruction memory model, combinational on the address.
    always_comb begin
        imem_data = mem_word(imem_adr);
        if (halt_mode && imem_adr == 32'd16) imem_data = 32'hFFFF_FFFF;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = mem_word(pc);
        exp_q.push_back(e);
    endtask

    // Monitor: compare every accepted instruction against the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_handshake", out_pc, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("hs_pc", out_pc, e.pc);
                check("hs_inst", out_inst, e.inst);
                check("hs_pc4", out_pc4, e.pc + 32'd4);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirect();
        br_taken  = 1'b0;
        br_imm    = 16'd0;
        jmp       = 1'b0;
        jmp_addr  = 26'd0;
        jr        = 1'b0;
        jr_target = 32'd0;
    endtask

    // Reset, release, and wait one edge: the first instruction is presented.
    task automatic start_phase();
        rst       = 1'b1;
        out_ready = 1'b0;
        clear_redirect();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic accept(input int n);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Redirect on the presented instruction; returns with the target presented.
    task automatic redirect(input logic b, input logic [15:0] imm, input logic j,
                            input logic [25:0] ja, input logic r, input logic [31:0] rt);
        br_taken  = b;
        br_imm    = imm;
        jmp       = j;
        jmp_addr  = ja;
        jr        = r;
        jr_target = rt;
        out_ready = 1'b1;
        tick();
        check("bubble_valid", 32'(out_valid), 32'd0);
        clear_redirect();
        tick();
    endtask

    task automatic end_phase(input string name);
        out_ready = 1'b0;
        check(name, exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total     = 0;
        bad       = 0;
        halt_mode = 1'b0;
        rst       = 1'b1;
        out_ready = 1'b0;
        clear_redirect();

        // Reset state.
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_adr", imem_adr, 32'd0);
        check("rst_inst", out_inst, 32'd0);
        check("rst_pc", out_pc, 32'd0);

        // Sequential fetch with a three-cycle stall at out_pc=8.
        rst = 1'b0;
        push(32'd0); push(32'd4); push(32'd8); push(32'd12);
        tick();
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_pc", out_pc, 32'd0);
        accept(2);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", out_pc, 32'd8);
            check("stall_inst", out_inst, mem_word(32'd8));
            check("stall_adr", imem_adr, 32'd12);
            check("stall_valid", 32'(out_valid), 32'd1);
        end
        accept(1);
        check("resume_pc", out_pc, 32'd12);
        accept(1);
        check("seq_count", fetch_count, 32'd4);
        end_phase("seq_drained");

        // Reset while stalled with a valid instruction presented.
        rst = 1'b1;
        tick();
        check("stall_rst_valid", 32'(out_valid), 32'd0);
        check("stall_rst_count", fetch_count, 32'd0);
        check("stall_rst_adr", imem_adr, 32'd0);

        // Branch, positive offset: 8 + 4 + 12 = 24.
        start_phase();
        push(32'd0); push(32'd4); push(32'd8); push(32'd24);
        accept(2);
        redirect(1'b1, 16'h0003, 1'b0, 26'd0, 1'b0, 32'd0);
        check("brpos_pc", out_pc, 32'd24);
        check("brpos_inst", out_inst, mem_word(32'd24));
        accept(1);
        end_phase("brpos_drained");

        // Branch, negative offset: 8 + 4 - 8 = 4.
        start_phase();
        push(32'd0); push(32'd4); push(32'd8); push(32'd4);
        accept(2);
        redirect(1'b1, 16'hFFFE, 1'b0, 26'd0, 1'b0, 32'd0);
        check("brneg_pc", out_pc, 32'd4);
        accept(1);
        end_phase("brneg_drained");

        // Jump priority from out_pc=32'h1000_0010.
        start_phase();
        push(32'd0); push(32'h1000_0010); push(32'h0000_0200);
        push(32'h1000_0010); push(32'h1000_0100);
        redirect(1'b0, 16'd0, 1'b0, 26'd0, 1'b1, 32'h1000_0010);
        check("jr_setup_pc", out_pc, 32'h1000_0010);
        redirect(1'b1, 16'h0003, 1'b1, 26'h40, 1'b1, 32'h0000_0200);
        check("jr_wins_pc", out_pc, 32'h0000_0200);
        redirect(1'b0, 16'd0, 1'b0, 26'd0, 1'b1, 32'h1000_0010);
        redirect(1'b1, 16'h0003, 1'b1, 26'h40, 1'b0, 32'h0000_0200);
        check("jmp_pc", out_pc, 32'h1000_0100);
        accept(1);
        check("jmp_count", fetch_count, 32'd5);
        end_phase("jmp_drained");

        // PC wrap: JR to the last word, then sequential fetch wraps to 0.
        start_phase();
        push(32'd0); push(32'hFFFF_FFFC); push(32'd0);
        redirect(1'b0, 16'd0, 1'b0, 26'd0, 1'b1, 32'hFFFF_FFFC);
        check("wrap_pc4", out_pc4, 32'd0);
        accept(1);
        check("wrap_pc", out_pc, 32'd0);
        check("wrap_adr", imem_adr, 32'd4);
        accept(1);
        end_phase("wrap_drained");

        // Halt word at 16, then reset restarts fetching.
        halt_mode = 1'b1;
        start_phase();
        push(32'd0); push(32'd4); push(32'd8); push(32'd12);
        accept(4);
        for (int i = 0; i < 3; i++) begin
            check("halt_valid", 32'(out_valid), 32'd0);
            check("halt_flag", 32'(halted), 32'd1);
            check("halt_adr", imem_adr, 32'd16);
            check("halt_count", fetch_count, 32'd4);
            tick();
        end
        end_phase("halt_drained");
        rst = 1'b1;
        tick();
        check("halt_rst_flag", 32'(halted), 32'd0);
        check("halt_rst_adr", imem_adr, 32'd0);
        rst = 1'b0;
        push(32'd0); push(32'd4);
        tick();
        check("restart_pc", out_pc, 32'd0);
        accept(2);
        check("restart_next_pc", out_pc, 32'd8);
        end_phase("restart_drained");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
